// File: rtl/sram_uart_dbg_pkg.sv
// Shared constants for the UART debug master on the sram bus.
//   - Command opcodes and reply bytes of the byte protocol.
//   - Controller state encoding (legacy-compatible localparam constants).
//   - DATA_BYTES: number of bytes in one 64-bit bus beat.
package sram_uart_dbg_pkg;

   localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
   localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
   localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_ERR  = 8'h3F;  // '?'

   localparam int DATA_BYTES = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_ADDR   = 3'd1;
   localparam state_t ST_MASK   = 3'd2;
   localparam state_t ST_DATA   = 3'd3;
   localparam state_t ST_REQ    = 3'd4;
   localparam state_t ST_RDWAIT = 3'd5;
   localparam state_t ST_RESP   = 3'd6;
   localparam state_t ST_ERR    = 3'd7;

endpackage

// File: rtl/sram_uart_dbg_master.sv
// UART-driven debug bridge acting as a second initiator on the 64-bit sram bus.
// Parses byte commands from the uart_phy receiver, performs one single-beat
// read or write through the bus arbiter, and replies over the uart_phy transmitter.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_data, rx_ready   received byte + one-cycle valid pulse (no backpressure)
//   tx_data, tx_valid,  reply byte; tx_valid is held until tx_ready accepts it
//   tx_ready
//   bus_req, bus_gnt    arbiter request / combinational grant
//   addra, dina, douta, sram bus: byte address, write data, read data (1-cycle
//   ena, wea            latency), access strobe, byte write enables (0 = read)
//   busy                high whenever the controller is not idle
//   err_count           saturating protocol-error counter
//   state_dbg           current controller state for debug/checkers
//
// Handshakes: the tx byte transfers on the cycle where tx_valid && tx_ready are
// both high; tx_data/tx_valid never change while waiting. The bus access is the
// single cycle where bus_req && bus_gnt (ena) is high.
module sram_uart_dbg_master
   import sram_uart_dbg_pkg::*;
#(
   parameter int LEN_ADDR       = 64,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                rx_ready,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                bus_req,
   input  logic                bus_gnt,
   output logic [LEN_ADDR-1:0] addra,
   output logic [63:0]         dina,
   input  logic [63:0]         douta,
   output logic                ena,
   output logic [7:0]          wea,
   output logic                busy,
   output logic [7:0]          err_count,
   output logic [2:0]          state_dbg
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic [7:0]    op_q;
   logic [7:0]    mask_q;
   logic [63:0]   addr_q;
   logic [63:0]   data_q;
   logic [63:0]   tx_sh;
   logic [2:0]    byte_cnt;
   logic [3:0]    tx_cnt;
   logic [TW-1:0] tmo_cnt;

   logic is_write;
   logic in_field;
   logic tmo_expire;
   logic late_byte;
   logic bad_op;
   logic err_evt;
   logic tx_fire;

   assign is_write   = (op_q == OP_WRITE);
   assign in_field   = (state == ST_ADDR) || (state == ST_MASK) || (state == ST_DATA);
   // A byte arriving in the expiry cycle wins over the timeout.
   assign tmo_expire = in_field && !rx_ready && (tmo_cnt == TMO_LAST);
   assign late_byte  = rx_ready && ((state == ST_REQ) || (state == ST_RDWAIT) ||
                                    (state == ST_RESP) || (state == ST_ERR));
   assign bad_op     = rx_ready && (state == ST_IDLE) &&
                       (rx_data != OP_READ) && (rx_data != OP_WRITE);
   // Coincident error sources collapse into a single increment.
   assign err_evt    = bad_op || late_byte || tmo_expire;
   assign tx_fire    = tx_valid && tx_ready;

   assign busy      = (state != ST_IDLE);
   assign tx_valid  = (state == ST_RESP) || (state == ST_ERR);
   assign tx_data   = tx_sh[7:0];
   assign bus_req   = (state == ST_REQ);
   assign ena       = bus_req && bus_gnt;
   assign wea       = (bus_req && is_write) ? mask_q : 8'h00;
   // Address bytes above LEN_ADDR are received but never reach the bus.
   assign addra     = addr_q[LEN_ADDR-1:0];
   assign dina      = data_q;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= 8'h00;
         mask_q    <= 8'h00;
         addr_q    <= 64'd0;
         data_q    <= 64'd0;
         tx_sh     <= 64'd0;
         byte_cnt  <= 3'd0;
         tx_cnt    <= 4'd0;
         tmo_cnt   <= '0;
         err_count <= 8'h00;
      end else begin
         if (err_evt && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;

         if (rx_ready || !in_field)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + TW'(1);

         case (state)
            ST_IDLE: begin
               if (rx_ready) begin
                  op_q     <= rx_data;
                  byte_cnt <= 3'd0;
                  if ((rx_data == OP_READ) || (rx_data == OP_WRITE)) begin
                     state <= ST_ADDR;
                  end else begin
                     tx_sh  <= {56'd0, RSP_ERR};
                     tx_cnt <= 4'd1;
                     state  <= ST_ERR;
                  end
               end
            end

            ST_ADDR: begin
               if (rx_ready) begin
                  // Little-endian: first byte ends up in the least significant lane.
                  addr_q   <= {rx_data, addr_q[63:8]};
                  byte_cnt <= byte_cnt + 3'd1;
                  if (byte_cnt == 3'(DATA_BYTES - 1))
                     state <= is_write ? ST_MASK : ST_REQ;
               end else if (tmo_expire) begin
                  state <= ST_IDLE;
               end
            end

            ST_MASK: begin
               if (rx_ready) begin
                  mask_q <= rx_data;
                  state  <= ST_DATA;
               end else if (tmo_expire) begin
                  state <= ST_IDLE;
               end
            end

            ST_DATA: begin
               if (rx_ready) begin
                  data_q   <= {rx_data, data_q[63:8]};
                  byte_cnt <= byte_cnt + 3'd1;
                  if (byte_cnt == 3'(DATA_BYTES - 1)) begin
                     if (mask_q == 8'h00) begin
                        // Nothing to write: acknowledge without touching the bus.
                        tx_sh  <= {56'd0, RSP_ACK};
                        tx_cnt <= 4'd1;
                        state  <= ST_RESP;
                     end else begin
                        state <= ST_REQ;
                     end
                  end
               end else if (tmo_expire) begin
                  state <= ST_IDLE;
               end
            end

            ST_REQ: begin
               if (bus_gnt) begin
                  if (is_write) begin
                     tx_sh  <= {56'd0, RSP_ACK};
                     tx_cnt <= 4'd1;
                     state  <= ST_RESP;
                  end else begin
                     state <= ST_RDWAIT;
                  end
               end
            end

            ST_RDWAIT: begin
               tx_sh  <= douta;
               tx_cnt <= 4'(DATA_BYTES);
               state  <= ST_RESP;
            end

            ST_RESP, ST_ERR: begin
               if (tx_fire) begin
                  tx_sh  <= {8'h00, tx_sh[63:8]};
                  tx_cnt <= tx_cnt - 4'd1;
                  if (tx_cnt == 4'd1)
                     state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_uart_dbg_master.sv
// Self-checking bench for sram_uart_dbg_master: directed scenarios plus a
// randomized command stream, checked against a transaction-level model
// (expected tx byte queue, expected bus-access queue, expected error count,
// and a sparse memory image).
module tb_sram_uart_dbg_master;
   import sram_uart_dbg_pkg::*;

   localparam int TMO = 100;

   typedef struct packed {
      logic [63:0] addr;
      logic [7:0]  wea;
      logic [63:0] dina;
   } bus_t;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        bus_req;
   logic        bus_gnt;
   logic [63:0] addra;
   logic [63:0] dina;
   logic [63:0] douta;
   logic        ena;
   logic [7:0]  wea;
   logic        busy;
   logic [7:0]  err_count;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  exp_tx[$];
   bus_t        exp_bus[$];
   int          exp_err    = 0;
   int          gnt_delay  = 0;
   int          req_cycles = 0;
   int          req_wait   = 0;
   int          ena_seen   = 0;
   int          tx_seen    = 0;

   logic [63:0] model_mem [logic [60:0]];
   logic [63:0] resp_mem  [logic [60:0]];

   sram_uart_dbg_master #(.LEN_ADDR(64), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .bus_req(bus_req), .bus_gnt(bus_gnt),
      .addra(addra), .dina(dina), .douta(douta),
      .ena(ena), .wea(wea),
      .busy(busy), .err_count(err_count), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Background pattern for memory words nobody has written yet.
   function automatic logic [63:0] fill(input logic [60:0] idx);
      return ({3'b000, idx} * 64'h9E3779B97F4A7C15) ^ 64'hA5A5_0000_5A5A_FFFF;
   endfunction

   function automatic logic [63:0] model_rd(input logic [60:0] idx);
      return model_mem.exists(idx) ? model_mem[idx] : fill(idx);
   endfunction

   function automatic logic [63:0] resp_rd(input logic [60:0] idx);
      return resp_mem.exists(idx) ? resp_mem[idx] : fill(idx);
   endfunction

   // ---------------- environment: sram responder, arbiter, tx sink ----------------
   always @(posedge clk) begin : responder
      logic [63:0] cur;
      if (ena) begin
         if (wea == 8'h00) begin
            douta <= resp_rd(addra[63:3]);
         end else begin
            cur = resp_rd(addra[63:3]);
            for (int b = 0; b < 8; b++)
               if (wea[b]) cur[8*b +: 8] = dina[8*b +: 8];
            resp_mem[addra[63:3]] = cur;
         end
      end
   end

   // Grant is withheld for gnt_delay cycles of bus_req, then given.
   initial begin
      bus_gnt = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (bus_req) begin
            req_cycles++;
            bus_gnt = (req_cycles > gnt_delay);
         end else begin
            req_cycles = 0;
            bus_gnt    = 1'b0;
         end
      end
   end

   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         tx_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : monitor
      bus_t b;
      if (rst) begin
         req_wait = 0;
      end else begin
         if (bus_req && !ena) begin
            req_wait++;
            if (exp_bus.size() > 0) check("req_addr_stable", addra, exp_bus[0].addr);
         end
         if (ena) begin
            ena_seen++;
            if (exp_bus.size() == 0) begin
               check("ena_unexpected", 64'd1, 64'd0);
            end else begin
               b = exp_bus.pop_front();
               check("bus_addr", addra, b.addr);
               check("bus_wea", 64'(wea), 64'(b.wea));
               if (b.wea != 8'h00) check("bus_dina", dina, b.dina);
               check("gnt_wait", 64'(req_wait), 64'(gnt_delay));
            end
            req_wait = 0;
         end
         if (tx_valid && tx_ready) begin
            tx_seen++;
            if (exp_tx.size() == 0) check("tx_unexpected", 64'(tx_data), 64'h100);
            else check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic model_read(input logic [63:0] a);
      logic [63:0] d;
      exp_bus.push_back('{addr: a, wea: 8'h00, dina: 64'd0});
      d = model_rd(a[63:3]);
      for (int i = 0; i < 8; i++) exp_tx.push_back(d[8*i +: 8]);
   endtask

   task automatic model_write(input logic [63:0] a, input logic [7:0] m, input logic [63:0] d);
      logic [63:0] cur;
      if (m != 8'h00) begin
         exp_bus.push_back('{addr: a, wea: m, dina: d});
         cur = model_rd(a[63:3]);
         for (int b = 0; b < 8; b++)
            if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
         model_mem[a[63:3]] = cur;
      end
      exp_tx.push_back(RSP_ACK);
   endtask

   task automatic model_bad();
      exp_tx.push_back(RSP_ERR);
      if (exp_err < 255) exp_err++;
   endtask

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      @(posedge clk);
      #2;
      rx_ready = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_read(input logic [63:0] a);
      send_byte(OP_READ);
      for (int i = 0; i < 8; i++) begin gap(); send_byte(a[8*i +: 8]); end
   endtask

   task automatic send_write(input logic [63:0] a, input logic [7:0] m, input logic [63:0] d);
      send_byte(OP_WRITE);
      for (int i = 0; i < 8; i++) begin gap(); send_byte(a[8*i +: 8]); end
      gap();
      send_byte(m);
      for (int i = 0; i < 8; i++) begin gap(); send_byte(d[8*i +: 8]); end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_tx_drained"}, 64'(exp_tx.size()), 64'd0);
      check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int          e0;
      int          t0;
      logic [63:0] a;
      logic [63:0] d;
      logic [7:0]  m;
      logic [7:0]  op;

      rst      = 1'b1;
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_bus_req", 64'(bus_req), 64'd0);
      check("rst_ena", 64'(ena), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_wea", 64'(wea), 64'd0);
      check("rst_addra", addra, 64'd0);
      check("rst_dina", dina, 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      @(posedge clk);
      #2;
      rst = 1'b0;

      // 1: full-mask write with grant available immediately
      gnt_delay = 0;
      e0 = ena_seen;
      model_write(64'h1010, 8'hFF, 64'h1122334455667788);
      send_write(64'h1010, 8'hFF, 64'h1122334455667788);
      wait_idle("t1");
      check("t1_ena_cycles", 64'(ena_seen - e0), 64'd1);

      // 2: read back with the grant withheld for 5 request cycles
      gnt_delay = 5;
      e0 = ena_seen;
      model_read(64'h1010);
      send_read(64'h1010);
      wait_idle("t2");
      check("t2_ena_cycles", 64'(ena_seen - e0), 64'd1);

      // 3: unknown opcode
      gnt_delay = 0;
      e0 = ena_seen;
      model_bad();
      send_byte(8'h41);
      wait_idle("t3");
      check("t3_ena_cycles", 64'(ena_seen - e0), 64'd0);

      // 4: partial address then silence -> timeout abort, no reply
      e0 = ena_seen;
      send_byte(OP_READ);
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'h00);
      repeat (TMO / 2) @(negedge clk);
      check("t4_busy_before_timeout", 64'(busy), 64'd1);
      exp_err++;
      repeat (TMO / 2 + 10) @(negedge clk);
      check("t4_busy_after_timeout", 64'(busy), 64'd0);
      check("t4_err_count", 64'(err_count), 64'(exp_err));
      check("t4_ena_cycles", 64'(ena_seen - e0), 64'd0);
      gnt_delay = 2;
      model_read(64'h1010);
      send_read(64'h1010);
      wait_idle("t4_read");

      // 5: stray byte during the read reply, then a zero-mask write
      gnt_delay = 1;
      model_read(64'h2008);
      send_read(64'h2008);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_valid) break;
      end
      check("t5_in_resp", 64'(tx_valid), 64'd1);
      exp_err++;
      send_byte(8'hAA);
      wait_idle("t5_read");
      e0 = ena_seen;
      model_write(64'h2010, 8'h00, 64'hDEADBEEF_CAFEF00D);
      send_write(64'h2010, 8'h00, 64'hDEADBEEF_CAFEF00D);
      wait_idle("t5_nomask");
      check("t5_nomask_ena", 64'(ena_seen - e0), 64'd0);

      // randomized command stream
      for (int n = 0; n < 24; n++) begin
         a = 64'h2000 + 64'($urandom_range(0, 7) << 3) + 64'($urandom_range(0, 7));
         gnt_delay = $urandom_range(0, 4);
         case ($urandom_range(0, 4))
            0, 1: begin
               model_read(a);
               send_read(a);
            end
            2, 3: begin
               m = 8'($urandom);
               d = {$urandom, $urandom};
               model_write(a, m, d);
               send_write(a, m, d);
            end
            default: begin
               do op = 8'($urandom); while ((op == OP_READ) || (op == OP_WRITE));
               model_bad();
               send_byte(op);
            end
         endcase
         wait_idle("rand");
      end

      // 6: reset after three reply bytes of a read
      gnt_delay = 0;
      model_read(64'h1010);
      t0 = tx_seen;
      send_read(64'h1010);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         if (tx_seen >= t0 + 3) break;
      end
      check("t6_three_bytes", 64'(tx_seen - t0), 64'd3);
      rst = 1'b1;
      @(negedge clk);
      check("t6_tx_valid", 64'(tx_valid), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_err_count", 64'(err_count), 64'd0);
      exp_tx.delete();
      exp_bus.delete();
      exp_err = 0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_read(64'h1010);
      send_read(64'h1010);
      wait_idle("t6_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_uart_dbg_master.md
Name: sram_uart_dbg_master

Overview:
- UART-driven debug bridge and second initiator on the 64-bit sram bus (addra/dina/douta/ena/wea).
- Parses byte commands from uart_phy rx and issues single-beat reads/writes through a req/gnt arbiter in front of the data xbar.
- Returns read data or a write ack over uart_phy tx.
- Gives host-side memory/device peek/poke and program load without CPU involvement.

Parameters:
LEN_ADDR, 64, width of addra; upper address bytes received beyond LEN_ADDR are discarded.
TIMEOUT_CYCLES, 1000000, max clk cycles between command bytes before abort (10 ms at 100 MHz).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte from uart_phy
rx_ready  in  1  one-cycle pulse: rx_data valid; no backpressure
tx_data  out  8  byte to uart_phy
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  uart_phy accepts byte when tx_valid&&tx_ready
bus_req  out  1  request for sram bus
bus_gnt  in  1  arbiter grant, sampled combinationally
addra  out  LEN_ADDR  byte address (responders ignore [2:0])
dina  out  64  write data
douta  in  64  read data, valid 1 cycle after ena with wea==0
ena  out  1  access strobe
wea  out  8  byte write enables; 0 = read
busy  out  1  high in any state except IDLE
err_count  out  8  saturating protocol-error counter

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - tx_valid, bus_req, ena, busy = 0.
  - wea, addra, dina, tx_data, err_count = 0.
  - state = IDLE.
- Reset mid-operation: aborts immediately. tx_valid drops the same edge, even mid-handshake.
- Protocol, all multi-byte fields little-endian:
  - Read: 0x52 'R', addr[8]. Reply: 8 data bytes, LSB first.
  - Write: 0x57 'W', addr[8], mask[1], data[8]. Reply: 0x4B 'K'.
  - Any other opcode: reply 0x3F '?', err_count++.
- States:
  - IDLE: on rx_ready, latch opcode. R/W -> ADDR (byte cnt=0). Otherwise -> ERR.
  - ADDR: each rx_ready shifts a byte into addr. After the 8th byte: R -> REQ, W -> MASK.
  - MASK: one byte -> DATA.
  - DATA: 8 bytes shifted into dina -> REQ. If mask==0, skip REQ and go directly to RESP('K').
  - REQ: bus_req=1.
    - ena=(state==REQ)&&bus_gnt; wea=mask for W, 0 for R.
    - On grant: W -> RESP('K'); R -> RDWAIT.
    - No timeout while waiting for gnt.
  - RDWAIT: capture douta into the tx shift register -> RESP, count=8.
  - RESP: tx_valid=1 with the current byte. On tx_valid&&tx_ready: shift and decrement. At 0 -> IDLE.
  - ERR: send '?' with the same handshake -> IDLE.
- Exactly one ena cycle per valid command. addra/dina/wea stay stable from REQ entry through the grant cycle.
- Timeout:
  - Counter cleared on each rx_ready; active only in ADDR/MASK/DATA.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, err_count++, no bus access, no reply.
  - rx_ready in the same cycle as expiry: byte wins, counter cleared.
- rx_ready in REQ/RDWAIT/RESP/ERR: byte dropped, err_count++. The current transaction is unaffected.
- err_count saturates at 255. Two error events in one cycle count once.

Decomposition:
- Package sram_uart_dbg_pkg holds:
  - opcode/reply constants: OP_READ=8'h52, OP_WRITE=8'h57, RSP_ACK=8'h4B, RSP_ERR=8'h3F;
  - state enum (IDLE, ADDR, MASK, DATA, REQ, RDWAIT, RESP, ERR);
  - DATA_BYTES=8.
- Single module. Shift registers and the timeout counter are inline; no sub-module is warranted.

Test Plan:
1. Write: bytes 57, 10 10 00 00 00 00 00 00, FF, 88 77 66 55 44 33 22 11, gnt tied 1 -> exactly one cycle of ena=1, wea=FF, addra=0x1010, dina=0x1122334455667788; tx 0x4B; busy returns 0.
2. Read with gnt withheld 5 cycles: 52 + addr 0x1010; model douta=0x1122334455667788 -> bus_req high 5 cycles with ena=0, then one ena cycle with wea=0; tx 88 77 66 55 44 33 22 11 in order. tx_ready toggled randomly, no byte lost or duplicated.
3. Opcode 0x41 -> tx 0x3F, err_count=1, ena never asserted.
4. TIMEOUT_CYCLES=100: 52 + 3 addr bytes, then silence 100 cycles -> IDLE, err_count+1, no ena. A following full read completes correctly.
5. Byte injected during RESP -> dropped, err_count+1, response bytes unchanged; mask=00 write -> no ena, tx 0x4B.
6. rst asserted after 3 RESP bytes -> next cycle tx_valid=0, busy=0, err_count=0; a fresh command then works.
